photon_fire_scheduler: RTL and testbench

- Round-robin scheduler that shares one photonic scoring tile among NUM_REQ digital requesters.
- Each requester supplies a query amplitude and key phase. The block arbitrates, drives the tile's DAC/fire interface, and tracks in-flight pulses with a tag pipeline matched to the tile's fixed optical latency.
- It returns each digital score tagged with the originating requester.
- It enforces an in-flight credit limit and provides a drain/halt sequence for recalibration.

---
 rtl/photon_fire_scheduler_if.sv | 40 ++++
 rtl/photon_fire_scheduler.sv | 169 ++++++++++++++++
 tb/tb_photon_fire_scheduler.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/photon_fire_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : photon_fire_scheduler_if
// Purpose  : Bundles the requester handshake, the photonic tile DAC/ADC
//            interface and the tagged result stream of the fire scheduler.
// Ports    : master - scheduler side (drives gnt, tile_*, res_*)
//            slave  - requesters / tile / result consumer side
// Revision : 1.0 - initial release
// ============================================================================
interface photon_fire_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  // requester handshake
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*32-1:0] req_q;
  logic [NUM_REQ*32-1:0] req_k;
  logic [NUM_REQ-1:0]    gnt;
  // photonic tile
  logic [31:0]           tile_q;
  logic [31:0]           tile_k;
  logic                  tile_fire;
  logic [31:0]           tile_score;
  logic                  tile_score_valid;
  // tagged results
  logic                  res_valid;
  logic [31:0]           res_score;
  logic [ID_W-1:0]       res_id;

  modport master (
    input  req, req_q, req_k, tile_score, tile_score_valid,
    output gnt, tile_q, tile_k, tile_fire, res_valid, res_score, res_id
  );

  modport slave (
    output req, req_q, req_k, tile_score, tile_score_valid,
    input  gnt, tile_q, tile_k, tile_fire, res_valid, res_score, res_id
  );
endinterface
`default_nettype wire

// File: rtl/photon_fire_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : photon_fire_scheduler
// Purpose  : Round-robin scheduler sharing one photonic scoring tile among
//            NUM_REQ requesters. Tracks in-flight pulses with a tag pipe
//            matched to the tile's optical latency, returns tagged scores,
//            enforces an in-flight credit limit and offers drain/halt.
// Ports    : clk, rst        - clock, asynchronous active-high reset
//            bus (master)    - requester handshake, tile DAC/ADC, results
//            drain_req       - level request to stop issuing and empty path
//            drain_done      - halted with nothing in flight
//            inflight        - fired-but-unreturned pulse count
//            err_seq         - sticky tag/return mismatch flag
// Revision : 1.0 - initial release
// ============================================================================
module photon_fire_scheduler #(
  parameter int NUM_REQ         = 4,
  parameter int OPTICAL_LATENCY = 10,
  parameter int MAX_INFLIGHT    = 8,
  parameter int ID_W            = 2,
  localparam int CNT_W          = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  photon_fire_scheduler_if.master bus,
  input  logic                    drain_req,
  output logic                    drain_done,
  output logic [CNT_W-1:0]        inflight,
  output logic                    err_seq
);

  // Tag pipe is captured one cycle behind tile_fire, so its tail lines up
  // with the tile's score_valid OPTICAL_LATENCY+1 cycles after the fire.
  localparam int c_TAG_DEPTH = OPTICAL_LATENCY + 1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [ID_W-1:0]        r_rr_ptr;
  logic [ID_W-1:0]        r_fire_id;
  logic [c_TAG_DEPTH-1:0] r_tag_v;
  logic [ID_W-1:0]        r_tag_id [c_TAG_DEPTH];
  logic [CNT_W-1:0]       r_inflight;
  logic                   r_err_seq;

  logic                   w_found;
  logic [ID_W-1:0]        w_win_id;
  logic [31:0]            w_win_q;
  logic [31:0]            w_win_k;
  logic                   w_credit_ok;
  logic                   w_xfer;
  logic                   w_tail_v;
  logic [ID_W-1:0]        w_tail_id;

  assign inflight  = r_inflight;
  assign err_seq   = r_err_seq;
  assign w_tail_v  = r_tag_v[c_TAG_DEPTH-1];
  assign w_tail_id = r_tag_id[c_TAG_DEPTH-1];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    drain_done  = 1'b0;
    case (r_state)
      ST_RUN:   if (drain_req) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (r_inflight == '0) w_state_nxt = ST_HALT;
      ST_HALT: begin
        drain_done = 1'b1;
        if (!drain_req) w_state_nxt = ST_RUN;
      end
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  // ------------------------------------------------------- arbitration
  // Search begins one past the last winner so every requester is reached
  // within NUM_REQ grants.
  always_comb begin
    int idx;
    idx      = 0;
    w_found  = 1'b0;
    w_win_id = '0;
    w_win_q  = '0;
    w_win_k  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(r_rr_ptr) + i) % NUM_REQ;
      if (!w_found && bus.req[idx]) begin
        w_found  = 1'b1;
        w_win_id = ID_W'(idx);
        w_win_q  = bus.req_q[idx*32 +: 32];
        w_win_k  = bus.req_k[idx*32 +: 32];
      end
    end
  end

  assign w_credit_ok = (r_inflight < CNT_W'(MAX_INFLIGHT));
  // drain_req blocks grants in the same cycle, before the FSM leaves RUN
  assign w_xfer  = (r_state == ST_RUN) && !drain_req && w_credit_ok && w_found;
  assign bus.gnt = w_xfer ? (NUM_REQ'(1) << w_win_id) : '0;

  // ------------------------------------------------------ fire datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.tile_q    <= '0;
      bus.tile_k    <= '0;
      bus.tile_fire <= 1'b0;
      r_fire_id     <= '0;
      r_rr_ptr      <= ID_W'(NUM_REQ - 1);
    end else begin
      bus.tile_fire <= w_xfer;
      if (w_xfer) begin
        bus.tile_q <= w_win_q;
        bus.tile_k <= w_win_k;
        r_fire_id  <= w_win_id;
        r_rr_ptr   <= w_win_id;
      end
    end
  end

  // ----------------------------------------------------------- tag pipe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag_v <= '0;
      for (int i = 0; i < c_TAG_DEPTH; i++) r_tag_id[i] <= '0;
    end else begin
      r_tag_v     <= {r_tag_v[c_TAG_DEPTH-2:0], bus.tile_fire};
      r_tag_id[0] <= r_fire_id;
      for (int i = 1; i < c_TAG_DEPTH; i++) r_tag_id[i] <= r_tag_id[i-1];
    end
  end

  // ------------------------------------------- returns, credits, errors
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.res_valid <= 1'b0;
      bus.res_score <= '0;
      bus.res_id    <= '0;
      r_inflight    <= '0;
      r_err_seq     <= 1'b0;
    end else begin
      // a lone tag or a lone score is a sequencing fault: flag, never emit
      bus.res_valid <= w_tail_v & bus.tile_score_valid;
      if (w_tail_v && bus.tile_score_valid) begin
        bus.res_score <= bus.tile_score;
        bus.res_id    <= w_tail_id;
      end
      if (w_tail_v ^ bus.tile_score_valid) r_err_seq <= 1'b1;

      // tail valid releases a credit even on mismatch
      case ({w_xfer, w_tail_v})
        2'b10: if (r_inflight < CNT_W'(MAX_INFLIGHT)) r_inflight <= r_inflight + 1'b1;
        2'b01: if (r_inflight != '0) r_inflight <= r_inflight - 1'b1;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_photon_fire_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_photon_fire_scheduler
// Purpose  : Scoreboard bench for photon_fire_scheduler. Stimulus process
//            drives requests/drain and a transaction-level model; a monitor
//            process plays the tile and checks fires and tagged results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_photon_fire_scheduler;
  localparam int NUM_REQ = 4;
  localparam int LAT     = 10;
  localparam int MAXF    = 8;
  localparam int ID_W    = 2;
  localparam int CNT_W   = $clog2(MAXF + 1);

  localparam int M_RUN = 0, M_DRAIN = 1, M_HALT = 2;

  logic clk = 1'b0;
  logic rst;
  logic drain_req;
  logic drain_done;
  logic [CNT_W-1:0] inflight;
  logic err_seq;

  always #5 clk = ~clk;

  photon_fire_scheduler_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  photon_fire_scheduler #(
    .NUM_REQ(NUM_REQ), .OPTICAL_LATENCY(LAT), .MAX_INFLIGHT(MAXF), .ID_W(ID_W)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.master), .drain_req(drain_req),
    .drain_done(drain_done), .inflight(inflight), .err_seq(err_seq)
  );

  typedef struct { int due; logic [31:0] q; logic [31:0] k; } fire_t;
  typedef struct { int due; logic [31:0] score; logic [ID_W-1:0] id; } res_t;

  int          cyc = 0;
  fire_t       fire_q[$];
  res_t        res_q[$];
  logic        ret_v[int];
  logic [31:0] ret_s[int];
  int          xfers[$];
  int          vectors = 0;
  int          miscompares = 0;

  // model / stimulus state
  logic        pend[NUM_REQ];
  logic [31:0] pq[NUM_REQ];
  logic [31:0] pk[NUM_REQ];
  int          mrr;
  int          mstate;
  logic        merr;
  logic        inject;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------- monitor + tile
  always @(negedge clk) begin
    fire_t f;
    res_t  r;
    if (rst === 1'b0) begin
      if (bus.tile_fire === 1'b1) begin
        if (fire_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_fire: got fire expected none (cycle %0d)", cyc);
        end else begin
          f = fire_q.pop_front();
          chk("fire_cycle", 64'(cyc), 64'(f.due));
          chk("tile_q", 64'(bus.tile_q), 64'(f.q));
          chk("tile_k", 64'(bus.tile_k), 64'(f.k));
        end
        // tile answers OPTICAL_LATENCY+1 cycles after the fire with q*k
        ret_v[cyc + LAT + 1] = 1'b1;
        ret_s[cyc + LAT + 1] = bus.tile_q * bus.tile_k;
      end
      if (bus.res_valid === 1'b1) begin
        if (res_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_res: got res_valid expected none (cycle %0d)", cyc);
        end else begin
          r = res_q.pop_front();
          chk("res_cycle", 64'(cyc), 64'(r.due));
          chk("res_score", 64'(bus.res_score), 64'(r.score));
          chk("res_id", 64'(bus.res_id), 64'(r.id));
        end
      end
    end
  end

  // In flight at cycle t: transfers made in cycles t-12 .. t-1.
  function automatic int model_inflight(input int t);
    int n = 0;
    foreach (xfers[i]) if (xfers[i] >= t - (LAT + 2) && xfers[i] <= t - 1) n++;
    return n;
  endfunction

  function automatic logic model_tail(input int t);
    foreach (xfers[i]) if (xfers[i] == t - (LAT + 2)) return 1'b1;
    return 1'b0;
  endfunction

  // One cycle, entered and left at a negedge.
  task automatic do_cycle();
    int t;
    int minf;
    int win;
    int r;
    logic sv;
    logic [NUM_REQ-1:0] exp_gnt;
    fire_t f;
    res_t  e;
    t    = cyc;
    minf = model_inflight(t);
    chk("inflight", 64'(inflight), 64'(minf));
    chk("drain_done", 64'(drain_done), 64'(mstate == M_HALT));
    chk("err_seq", 64'(err_seq), 64'(merr));

    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req[i]            = pend[i];
      bus.req_q[i*32 +: 32] = pq[i];
      bus.req_k[i*32 +: 32] = pk[i];
    end
    sv = ret_v.exists(t) ? 1'b1 : 1'b0;
    bus.tile_score       = sv ? ret_s[t] : $urandom;
    bus.tile_score_valid = sv | inject;
    if (sv) begin
      ret_v.delete(t);
      ret_s.delete(t);
    end
    #1;

    win = -1;
    if (mstate == M_RUN && !drain_req && minf < MAXF)
      for (int off = 1; off <= NUM_REQ; off++) begin
        r = (mrr + off) % NUM_REQ;
        if (pend[r] && win < 0) win = r;
      end
    exp_gnt = '0;
    if (win >= 0) exp_gnt[win] = 1'b1;
    chk("gnt", 64'(bus.gnt), 64'(exp_gnt));

    if (model_tail(t) != (sv | inject)) merr = 1'b1;
    if (win >= 0) begin
      f.due = t + 1; f.q = pq[win]; f.k = pk[win];
      fire_q.push_back(f);
      e.due = t + LAT + 3; e.score = pq[win] * pk[win]; e.id = ID_W'(win);
      res_q.push_back(e);
      xfers.push_back(t);
      mrr = win;
      pend[win] = 1'b0;
    end
    while (xfers.size() > 0 && xfers[0] < t - 20) void'(xfers.pop_front());

    case (mstate)
      M_RUN:   if (drain_req) mstate = M_DRAIN;
      M_DRAIN: if (minf == 0) mstate = M_HALT;
      default: if (!drain_req) mstate = M_RUN;
    endcase
    @(negedge clk);
  endtask

  task automatic refill(input int pct);
    for (int i = 0; i < NUM_REQ; i++)
      if (!pend[i] && $urandom_range(99) < pct) begin
        pend[i] = 1'b1;
        pq[i]   = $urandom;
        pk[i]   = $urandom;
      end
  endtask

  task automatic model_reset();
    fire_q.delete(); res_q.delete(); ret_v.delete(); ret_s.delete(); xfers.delete();
    mrr = NUM_REQ - 1; mstate = M_RUN; merr = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin pend[i] = 1'b0; pq[i] = '0; pk[i] = '0; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; drain_req = 1'b0; inject = 1'b0;
    bus.req = '0; bus.req_q = '0; bus.req_k = '0;
    bus.tile_score = '0; bus.tile_score_valid = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_fire", 64'(bus.tile_fire), 64'd0);
    chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
    chk("rst_inflight", 64'(inflight), 64'd0);
    chk("rst_gnt", 64'(bus.gnt), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // single transfer: 3*5 -> 15 tagged id 0
    pend[0] = 1'b1; pq[0] = 32'd3; pk[0] = 32'd5;
    do_cycle();
    repeat (16) do_cycle();

    // all requesters busy: round-robin order and credit ceiling
    repeat (30) begin refill(100); do_cycle(); end
    repeat (16) do_cycle();

    // drain with pulses in flight, then resume
    repeat (5) begin refill(100); do_cycle(); end
    drain_req = 1'b1;
    repeat (20) begin refill(100); do_cycle(); end
    drain_req = 1'b0;
    repeat (10) begin refill(100); do_cycle(); end

    // random traffic with random drain windows
    repeat (300) begin
      refill(40);
      if ($urandom_range(24) == 0) drain_req = ~drain_req;
      do_cycle();
    end
    drain_req = 1'b0;
    repeat (20) do_cycle();
    chk("fire_q_empty", 64'(fire_q.size()), 64'd0);
    chk("res_q_empty", 64'(res_q.size()), 64'd0);

    // stray score with nothing pending
    inject = 1'b1; do_cycle(); inject = 1'b0;
    repeat (5) do_cycle();

    // asynchronous reset five cycles into a pulse
    pend[2] = 1'b1; pq[2] = 32'd7; pk[2] = 32'd9;
    do_cycle();
    repeat (4) do_cycle();
    #2 rst = 1'b1;
    #1;
    chk("arst_fire", 64'(bus.tile_fire), 64'd0);
    chk("arst_res_valid", 64'(bus.res_valid), 64'd0);
    chk("arst_inflight", 64'(inflight), 64'd0);
    chk("arst_err_seq", 64'(err_seq), 64'd0);
    chk("arst_tile_q", 64'(bus.tile_q), 64'd0);
    chk("arst_gnt", 64'(bus.gnt), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (20) do_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
